wd_sector_buffer: RTL and testbench

Single-sector staging buffer between the WD task-file register block's data-port FIFO interface (host side) and the disk data path (disk side). It moves exactly one sector per transfer. A read command fills it from the disk, then drains it to the host. A write command fills it from the host, then drains it to the disk. It raises DRQ while the host owns the buffer and pulses sector_done once per completed sector, which the command FSM uses to decrement the sector count.

---
 rtl/wd_sector_buffer_if.sv | 30 +++
 rtl/wd_sector_buffer.sv | 130 +++++++++++++
 tb/tb_wd_sector_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wd_sector_buffer_if.sv
// Byte-wide host and disk port bundle for the WD single-sector buffer.
// The buffer takes the slave view; the host/disk side takes the master view.
interface wd_sector_buffer_if;
  logic [7:0] host_rdata;
  logic       host_rd;
  logic       host_empty;
  logic [7:0] host_wdata;
  logic       host_wr;
  logic       host_full;
  logic [7:0] disk_wdata;
  logic       disk_wr;
  logic       disk_full;
  logic [7:0] disk_rdata;
  logic       disk_rd;
  logic       disk_empty;

  modport slave (
    output host_rdata, host_empty, host_full,
    output disk_rdata, disk_empty, disk_full,
    input  host_rd, host_wdata, host_wr,
    input  disk_wdata, disk_wr, disk_rd
  );

  modport master (
    input  host_rdata, host_empty, host_full,
    input  disk_rdata, disk_empty, disk_full,
    output host_rd, host_wdata, host_wr,
    output disk_wdata, disk_wr, disk_rd
  );
endinterface

// File: rtl/wd_sector_buffer.sv
// One-sector staging RAM between the WD task-file data port and the disk path.
// Read commands fill from disk then drain to host; writes go the other way.
module wd_sector_buffer #(
  parameter int SECTOR_BYTES = 512,
  parameter int AW           = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xfer_start,
  input  logic              xfer_dir,
  input  logic              xfer_abort,
  wd_sector_buffer_if.slave bus,
  output logic              drq,
  output logic              busy,
  output logic [AW:0]       byte_ptr,
  output logic              sector_done,
  output logic              overrun
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DISK_FILL  = 3'd1;
  localparam logic [2:0] HOST_DRAIN = 3'd2;
  localparam logic [2:0] HOST_FILL  = 3'd3;
  localparam logic [2:0] DISK_DRAIN = 3'd4;

  localparam logic [AW:0] LAST = (AW+1)'(SECTOR_BYTES - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [2:0]  state, state_nxt;
  logic [AW:0] ptr, ptr_nxt;
  logic        done_nxt;
  logic        ovr_nxt;
  logic        last;
  logic        h_rd_ok, h_wr_ok, d_wr_ok, d_rd_ok;
  logic        bad, start_ok, we;
  logic [7:0]  wdata;
  logic [7:0]  mem [SECTOR_BYTES];

  always_comb begin
    h_rd_ok  = bus.host_rd && (state == HOST_DRAIN);
    h_wr_ok  = bus.host_wr && (state == HOST_FILL);
    d_wr_ok  = bus.disk_wr && (state == DISK_FILL);
    d_rd_ok  = bus.disk_rd && (state == DISK_DRAIN);
    bad      = (bus.host_rd && !h_rd_ok) ||
               (bus.host_wr && !h_wr_ok) ||
               (bus.disk_wr && !d_wr_ok) ||
               (bus.disk_rd && !d_rd_ok);
    start_ok = xfer_start && !xfer_abort && (state == IDLE);
    last     = (ptr == LAST);
    we       = (h_wr_ok || d_wr_ok) && !xfer_abort;
    wdata    = (state == HOST_FILL) ? bus.host_wdata : bus.disk_wdata;
    ovr_nxt  = start_ok ? 1'b0 : (overrun || bad);
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    if (xfer_abort) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: if (xfer_start) begin
          state_nxt = xfer_dir ? HOST_FILL : DISK_FILL;
          ptr_nxt   = '0;
        end
        DISK_FILL: if (d_wr_ok) begin
          state_nxt = last ? HOST_DRAIN : state;
          ptr_nxt   = last ? '0 : ptr + ONE;
        end
        HOST_DRAIN: if (h_rd_ok) begin
          state_nxt = last ? IDLE : state;
          ptr_nxt   = last ? '0 : ptr + ONE;
          done_nxt  = last;
        end
        HOST_FILL: if (h_wr_ok) begin
          state_nxt = last ? DISK_DRAIN : state;
          ptr_nxt   = last ? '0 : ptr + ONE;
        end
        DISK_DRAIN: if (d_rd_ok) begin
          state_nxt = last ? IDLE : state;
          ptr_nxt   = last ? '0 : ptr + ONE;
          done_nxt  = last;
        end
        default: begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      endcase
    end
  end

  // Flags decode the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      sector_done    <= 1'b0;
      overrun        <= 1'b0;
      drq            <= 1'b0;
      busy           <= 1'b0;
      bus.host_empty <= 1'b1;
      bus.host_full  <= 1'b1;
      bus.disk_empty <= 1'b1;
      bus.disk_full  <= 1'b1;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      sector_done    <= done_nxt;
      overrun        <= ovr_nxt;
      drq            <= (state_nxt == HOST_DRAIN) ||
                        (state_nxt == HOST_FILL);
      busy           <= (state_nxt != IDLE);
      bus.host_empty <= (state_nxt != HOST_DRAIN);
      bus.host_full  <= (state_nxt != HOST_FILL);
      bus.disk_empty <= (state_nxt != DISK_DRAIN);
      bus.disk_full  <= (state_nxt != DISK_FILL);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr[AW-1:0]] <= wdata;
  end

  assign bus.host_rdata = mem[ptr[AW-1:0]];
  assign bus.disk_rdata = mem[ptr[AW-1:0]];
  assign byte_ptr       = ptr;

endmodule

// File: tb/tb_wd_sector_buffer.sv
// Scoreboard bench for wd_sector_buffer: read, write, overrun, abort,
// back-to-back and mid-transfer reset scenarios.
module tb_wd_sector_buffer;
  localparam int N = 512;

  logic       clk = 1'b0;
  logic       reset;
  logic       xfer_start, xfer_dir, xfer_abort;
  logic       drq, busy, sector_done, overrun;
  logic [9:0] byte_ptr;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int drq_low = 0;
  logic [7:0] q[$];

  wd_sector_buffer_if bus();

  wd_sector_buffer #(.SECTOR_BYTES(N), .AW(9)) dut (
    .clk(clk), .reset(reset),
    .xfer_start(xfer_start), .xfer_dir(xfer_dir),
    .xfer_abort(xfer_abort), .bus(bus),
    .drq(drq), .busy(busy), .byte_ptr(byte_ptr),
    .sector_done(sector_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sector_done) done_cnt++;
  endtask

  task automatic start(logic dir);
    xfer_start = 1'b1;
    xfer_dir   = dir;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic abort();
    xfer_abort = 1'b1;
    tick();
    xfer_abort = 1'b0;
  endtask

  task automatic fill_disk(int n);
    for (int i = 0; i < n; i++) begin
      bus.disk_wdata = 8'(i);
      bus.disk_wr    = 1'b1;
      q.push_back(8'(i));
      tick();
    end
    bus.disk_wr = 1'b0;
  endtask

  task automatic fill_host(int n);
    for (int i = 0; i < n; i++) begin
      bus.host_wdata = 8'(i) ^ 8'hA5;
      bus.host_wr    = 1'b1;
      q.push_back(8'(i) ^ 8'hA5);
      tick();
    end
    bus.host_wr = 1'b0;
  endtask

  task automatic drain_host(int n);
    drq_low = 0;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else chk("host_rdata", bus.host_rdata, q.pop_front());
      if (!drq) drq_low++;
      bus.host_rd = 1'b1;
      tick();
    end
    bus.host_rd = 1'b0;
  endtask

  task automatic drain_disk(int n);
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else chk("disk_rdata", bus.disk_rdata, q.pop_front());
      bus.disk_rd = 1'b1;
      tick();
    end
    bus.disk_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    xfer_start = 0; xfer_dir = 0; xfer_abort = 0;
    bus.host_rd = 0; bus.host_wr = 0; bus.host_wdata = 0;
    bus.disk_rd = 0; bus.disk_wr = 0; bus.disk_wdata = 0;
    tick();
    tick();
    chk("rst_drq", drq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sector_done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ptr", byte_ptr, 0);
    chk("rst_flags", {bus.host_empty, bus.host_full,
                      bus.disk_empty, bus.disk_full}, 4'hF);
    reset = 1'b0;
    tick();

    // read path
    start(1'b0);
    chk("rd_busy", busy, 1);
    chk("rd_dfull", bus.disk_full, 0);
    chk("rd_drq0", drq, 0);
    fill_disk(N - 1);
    chk("rd_drq_pre", drq, 0);
    chk("rd_ptr511", byte_ptr, 511);
    fill_disk(1);
    chk("rd_drq_up", drq, 1);
    chk("rd_hempty", bus.host_empty, 0);
    chk("rd_ptr0", byte_ptr, 0);
    drain_host(N);
    chk("rd_drq_held", drq_low, 0);
    chk("rd_done", sector_done, 1);
    chk("rd_drq_down", drq, 0);
    chk("rd_idle", busy, 0);
    tick();
    chk("rd_done_pulse", sector_done, 0);
    chk("rd_done_cnt", done_cnt, 1);

    // write path
    start(1'b1);
    chk("wr_drq_up", drq, 1);
    chk("wr_hfull", bus.host_full, 0);
    fill_host(N - 1);
    chk("wr_drq_pre", drq, 1);
    fill_host(1);
    chk("wr_drq_down", drq, 0);
    chk("wr_dempty", bus.disk_empty, 0);
    drain_disk(N - 1);
    chk("wr_nodone", sector_done, 0);
    drain_disk(1);
    chk("wr_done", sector_done, 1);
    chk("wr_idle", busy, 0);
    chk("wr_done_cnt", done_cnt, 2);

    // overrun, busy start ignored
    start(1'b0);
    fill_disk(5);
    bus.host_rd = 1'b1;
    bus.host_wr = 1'b1;
    tick();
    bus.host_rd = 1'b0;
    bus.host_wr = 1'b0;
    chk("ovr_ptr", byte_ptr, 5);
    chk("ovr_set", overrun, 1);
    start(1'b1);
    chk("busy_start_ptr", byte_ptr, 5);
    chk("busy_start_drq", drq, 0);
    chk("busy_start_ovr", overrun, 1);
    abort();
    q.delete();
    chk("ovr_sticky", overrun, 1);
    start(1'b0);
    chk("ovr_clear", overrun, 0);

    // abort with a simultaneous disk write
    fill_disk(100);
    chk("ab_ptr100", byte_ptr, 100);
    bus.disk_wr = 1'b1;
    xfer_abort  = 1'b1;
    tick();
    bus.disk_wr = 1'b0;
    xfer_abort  = 1'b0;
    q.delete();
    chk("ab_idle", busy, 0);
    chk("ab_ptr", byte_ptr, 0);
    chk("ab_nodone", sector_done, 0);
    chk("ab_dfull", bus.disk_full, 1);
    chk("ab_ovr", overrun, 0);
    chk("ab_done_cnt", done_cnt, 2);

    // back-to-back write sectors
    start(1'b1);
    fill_host(N);
    drain_disk(N);
    chk("b2b_done1", sector_done, 1);
    start(1'b1);
    chk("b2b_drq", drq, 1);
    chk("b2b_done_pulse", sector_done, 0);
    fill_host(N);
    drain_disk(N);
    tick();
    chk("b2b_done_cnt", done_cnt, 5 - 1);

    // reset in HOST_DRAIN
    start(1'b0);
    fill_disk(N);
    drain_host(300);
    chk("mr_ptr", byte_ptr, 300);
    chk("mr_drq", drq, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_rst_drq", drq, 0);
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_ptr", byte_ptr, 0);
    chk("mr_rst_flags", {bus.host_empty, bus.host_full,
                         bus.disk_empty, bus.disk_full}, 4'hF);
    tick();
    chk("mr_nodone", done_cnt, 4);
    reset = 1'b0;
    q.delete();
    tick();
    start(1'b1);
    chk("mr_restart", drq, 1);
    fill_host(3);
    chk("mr_restart_ptr", byte_ptr, 3);
    abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 1 expected 0");
    $fatal(1);
  end
endmodule
